// File: rtl/object_mem_pkg.sv
// Shared constants for the 8x8 heart sprite ROM: geometry, palette and row bitmap.
// Bitmap bit (7-c) of row r is set where the heart covers column c.
package object_mem_pkg;

    localparam int SPRITE_W = 8;
    localparam int SPRITE_H = 8;

    localparam logic [2:0] COLOR_BLACK = 3'b000;
    localparam logic [2:0] COLOR_RED   = 3'b100;
    localparam logic [2:0] COLOR_WHITE = 3'b111;

    // Index 0 is the top row; leftmost column is the MSB of each row.
    localparam logic [0:SPRITE_H-1][SPRITE_W-1:0] SPRITE_BITMAP = {
        8'b01100110,
        8'b11111111,
        8'b11111111,
        8'b11111111,
        8'b01111110,
        8'b00111100,
        8'b00011000,
        8'b00000000
    };

endpackage

// File: rtl/object_mem_sprite_lut.sv
// Combinational sprite lookup: {row, col} address to RGB colour.
// Zero latency; no flow control.
module object_mem_sprite_lut
    import object_mem_pkg::*;
#(
    parameter int          ADDR_WIDTH = 6,
    parameter int          DATA_WIDTH = 3,
    parameter logic [DATA_WIDTH-1:0] FG_COLOR = COLOR_RED,
    parameter logic [DATA_WIDTH-1:0] BG_COLOR = COLOR_BLACK
) (
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] color
);

    logic [2:0] row_idx;
    logic [2:0] bit_idx;
    logic       pixel_on;

    assign row_idx  = address[5:3];
    assign bit_idx  = 3'd7 - address[2:0];
    assign pixel_on = SPRITE_BITMAP[row_idx][bit_idx];

    // An unknown pixel bit falls to the default branch and reads as background.
    always_comb begin
        color = BG_COLOR;
        case (pixel_on)
            1'b1:    color = FG_COLOR;
            default: color = BG_COLOR;
        endcase
    end

endmodule

// File: rtl/object_mem.sv
// Read-only 64x3 heart sprite memory with registered output; latency 1 (2 with OBJECT_MEM_OUTREG_EN).
// No enable or backpressure: address is sampled every rising edge; resetn clears q asynchronously.
module object_mem
    import object_mem_pkg::*;
#(
    parameter int          ADDR_WIDTH = 6,
    parameter int          DATA_WIDTH = 3,
    parameter logic [DATA_WIDTH-1:0] FG_COLOR = COLOR_RED,
    parameter logic [DATA_WIDTH-1:0] BG_COLOR = COLOR_BLACK
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] lut_color;

    object_mem_sprite_lut #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .FG_COLOR   (FG_COLOR),
        .BG_COLOR   (BG_COLOR)
    ) u_lut (
        .address (address),
        .color   (lut_color)
    );

`ifdef OBJECT_MEM_OUTREG_EN
    logic [DATA_WIDTH-1:0] stage1_q;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            stage1_q <= '0;
            q        <= '0;
        end else begin
            stage1_q <= lut_color;
            q        <= stage1_q;
        end
    end
`else
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            q <= '0;
        end else begin
            q <= lut_color;
        end
    end
`endif

endmodule

// File: tb/tb_object_mem.sv
// Scoreboard bench for object_mem: stimulus queues expected colours, a monitor compares them.
module tb_object_mem;

`ifdef OBJECT_MEM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       CLOCK_50;
    logic       resetn;
    logic [5:0] address;
    logic [2:0] q;

    object_mem dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .address  (address),
        .q        (q)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [2:0] exp;
        int         due;
        logic [5:0] addr;
    } sb_t;

    sb_t sb[$];
    int  cyc      = 0;
    int  checks   = 0;
    int  failures = 0;

    // Hand-entered heart rows, top to bottom, leftmost pixel in bit 7.
    localparam logic [7:0] HEART [8] = '{
        8'h66, 8'hFF, 8'hFF, 8'hFF, 8'h7E, 8'h3C, 8'h18, 8'h00
    };

    function automatic logic [2:0] model(input logic [5:0] a);
        logic [7:0] row;
        int         col;
        row = HEART[a[5:3]];
        col = 7 - int'(a[2:0]);
        return row[col] ? 3'b100 : 3'b000;
    endfunction

    task automatic check(input string nm, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: q=%b expected=%b at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Drive an address at the falling edge; its colour is due LAT edges later.
    task automatic drive(input logic [5:0] a, input logic [2:0] e);
        sb_t it;
        @(negedge CLOCK_50);
        address = a;
        it.exp  = e;
        it.due  = cyc + LAT;
        it.addr = a;
        sb.push_back(it);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: one sample per cycle, just after the rising edge.
    initial begin
        sb_t it;
        forever begin
            @(posedge CLOCK_50);
            cyc++;
            #1;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                it = sb.pop_front();
                check($sformatf("read addr=%0d", it.addr), q, it.exp);
            end
        end
    end

    initial begin
        resetn  = 1'b1;
        address = 6'd0;
        #2;
        resetn = 1'b0;
        #1;
        check("reset_no_clock", q, 3'b000);

        // Held in reset: address 1 must not reach q.
        drive(6'd1, 3'b000);
        drive(6'd1, 3'b000);
        drive(6'd1, 3'b000);
        drive(6'd1, 3'b100);
        resetn = 1'b1;
        drain();

        for (int i = 0; i < 64; i++) drive(6'(i), model(6'(i)));
        drain();

        // Spot checks with hand-computed colours.
        drive(6'd0,  3'b000);
        drive(6'd1,  3'b100);
        drive(6'd3,  3'b000);
        drive(6'd8,  3'b100);
        drive(6'd51, 3'b100);
        drive(6'd48, 3'b000);
        drive(6'd63, 3'b000);
        drive(6'd36, 3'b100);
        drive(6'd32, 3'b000);
        drive(6'd42, 3'b100);
        drain();

        // Back-to-back changes, no bubble.
        drive(6'd1, 3'b100);
        drive(6'd0, 3'b000);
        drive(6'd1, 3'b100);
        drive(6'd7, 3'b000);
        drive(6'd6, 3'b100);
        drain();

        // Asynchronous reset mid-cycle while q shows red.
        drive(6'd1, 3'b100);
        drain();
        @(posedge CLOCK_50);
        #3;
        check("pre_async_reset", q, 3'b100);
        resetn = 1'b0;
        #1;
        check("async_clear", q, 3'b000);
        drive(6'd1, 3'b000);
        drive(6'd8, 3'b100);
        resetn = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
